// File: rtl/multi_digit_led_driver.sv
// multi_digit_led_driver
//
// Time-multiplexes NUM_DIGITS common-anode seven-segment digits from a
// writable MSG_LEN-entry buffer of hex characters. Each digit slot begins with
// BLANK_CYCLES of all-anodes-off to suppress ghosting. The window into the
// buffer can scroll, and a scroll step only takes effect at a frame boundary,
// so a frame never mixes two windows.
//
// Ports
//   clk        system clock
//   reset      asynchronous, active-low reset
//   wr_en      buffer write strobe
//   wr_addr    buffer write address
//   wr_data    hex character to write
//   scroll_en  1 = advance the window on each scroll tick, 0 = hold
//   dp_mask    bit k = 1 lights the decimal point of digit k
//   an         anode enables, active low, an[NUM_DIGITS-1] is leftmost
//   seg        {a,b,c,d,e,f,g}, active low
//   dp         decimal point, active low
//   win_ptr    buffer index shown on the leftmost digit
module multi_digit_led_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int DIV_W        = 4,
  parameter int BLANK_CYCLES = 2,
  parameter int MSG_LEN      = 16,
  parameter int SCROLL_W     = 6
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [$clog2(MSG_LEN)-1:0] wr_addr,
  input  logic [3:0]                 wr_data,
  input  logic                       scroll_en,
  input  logic [NUM_DIGITS-1:0]      dp_mask,
  output logic [NUM_DIGITS-1:0]      an,
  output logic [6:0]                 seg,
  output logic                       dp,
  output logic [$clog2(MSG_LEN)-1:0] win_ptr
);

  localparam int AW = $clog2(MSG_LEN);
  localparam int DW = $clog2(NUM_DIGITS);
  localparam logic [NUM_DIGITS-1:0] ONE_HOT0 = NUM_DIGITS'(1);

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  logic [DIV_W-1:0]      cnt;
  logic [DIV_W-1:0]      cnt_nxt;
  logic [DW-1:0]         dig;
  logic [DW-1:0]         dig_nxt;
  logic [SCROLL_W-1:0]   scnt;
  logic                  pend;
  logic                  primed;
  logic [3:0]            mem [MSG_LEN];

  logic                  slot_end;
  logic                  frame_start;
  logic                  tick;
  logic                  load;
  logic                  adv;
  logic [AW-1:0]         win_nxt;
  logic [AW-1:0]         char_idx;
  logic [NUM_DIGITS-1:0] an_nxt;

  always_comb begin
    cnt_nxt     = cnt + 1'b1;
    slot_end    = (cnt == '1);
    dig_nxt     = dig;
    if (slot_end) begin
      dig_nxt = (dig == '0) ? DW'(NUM_DIGITS - 1) : dig - 1'b1;
    end
    frame_start = slot_end && (dig == '0);
    tick        = scroll_en && (scnt == '1);
    // The first slot after reset has no counter-wrap edge of its own, so it
    // loads on its first edge instead; this lands inside the blank cycles.
    load        = slot_end || !primed;
    adv         = frame_start && pend;
    win_nxt     = win_ptr + {{(AW-1){1'b0}}, adv};
    // Loads use the post-edge window so the whole new frame is consistent.
    char_idx    = win_nxt + AW'(NUM_DIGITS - 1) - AW'(dig_nxt);
    an_nxt      = '1;
    if (cnt_nxt >= DIV_W'(BLANK_CYCLES)) begin
      an_nxt = ~(ONE_HOT0 << dig_nxt);
    end
  end

  // Sequencing, scroll control and anode register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      dig     <= DW'(NUM_DIGITS - 1);
      scnt    <= '0;
      pend    <= 1'b0;
      primed  <= 1'b0;
      win_ptr <= '0;
      an      <= '1;
    end else begin
      cnt     <= cnt_nxt;
      dig     <= dig_nxt;
      primed  <= 1'b1;
      win_ptr <= win_nxt;
      an      <= an_nxt;
      if (scroll_en) begin
        scnt <= scnt + 1'b1;
      end
      // A tick on the frame-start edge survives to the following frame.
      if (tick) begin
        pend <= 1'b1;
      end else if (frame_start) begin
        pend <= 1'b0;
      end
    end
  end

  // Segment / decimal-point latch, loaded once per slot
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg <= 7'b1111111;
      dp  <= 1'b1;
    end else if (load) begin
      seg <= hex_to_seg(mem[char_idx]);
      dp  <= ~dp_mask[dig_nxt];
    end
  end

  // Message buffer; a load on the same edge as a write reads the old value
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MSG_LEN; i++) begin
        mem[i] <= 4'h0;
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

endmodule
